// File: rtl/comperator_axi_ip_v1_0_line_fetch.sv
// Line fetch: on each go request, captures up to BLOCK_SIZE pixels from an
// AXI4-Stream video input into a flat block register. A fetch ends early on
// tlast, and reports start-of-frame and misplaced-tuser status for the block.
module comperator_axi_ip_v1_0_line_fetch #(
  parameter int BLOCK_SIZE = 8,
  parameter int DATA_WIDTH = 24
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                go,
  output logic                                done,
  output logic                                eol,
  output logic                                sof,
  output logic                                misalign,
  input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                s_axis_tlast,
  input  logic                                s_axis_tuser,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]    block_data,
  output logic [$clog2(BLOCK_SIZE+1)-1:0]     pix_count
);

  localparam int CNT_W = $clog2(BLOCK_SIZE+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   tready_nxt;
  logic   done_nxt;

  logic   beat;
  logic   last_slot;
  logic   end_beat;
  logic   start;

  // The slot index always equals the number of beats captured so far,
  // so pix_count doubles as the write pointer into block_data.
  assign beat      = s_axis_tvalid & s_axis_tready;
  assign last_slot = (pix_count == CNT_W'(BLOCK_SIZE-1));
  assign end_beat  = beat & (s_axis_tlast | last_slot);
  assign start     = go & (state != FETCH);

  // State register; tready and done are flopped from the next state so they
  // change in the same edge as the state itself and never glitch.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      s_axis_tready <= tready_nxt;
      done          <= done_nxt;
    end
  end

  // Next-state logic; go is only honoured outside FETCH.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = FETCH;
      FETCH:   if (end_beat) state_nxt = DONE;
      DONE:    if (go) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode of the next state, registered above.
  always_comb begin
    tready_nxt = (state_nxt == FETCH);
    done_nxt   = (state_nxt == DONE);
  end

  // Capture datapath and block status flags; cleared on every accepted go so
  // slots left unwritten by an early tlast read back as zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      block_data <= '0;
      pix_count  <= '0;
      eol        <= 1'b0;
      sof        <= 1'b0;
      misalign   <= 1'b0;
    end else if (start) begin
      block_data <= '0;
      pix_count  <= '0;
      eol        <= 1'b0;
      sof        <= 1'b0;
      misalign   <= 1'b0;
    end else if (beat) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        if (pix_count == CNT_W'(i)) begin
          block_data[i*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata;
        end
      end
      pix_count <= pix_count + CNT_W'(1);
      if (pix_count == '0) begin
        sof <= s_axis_tuser;
      end else if (s_axis_tuser) begin
        misalign <= 1'b1;
      end
      if (end_beat) begin
        eol <= s_axis_tlast;
      end
    end
  end

endmodule

// File: tb/tb_comperator_axi_ip_v1_0_line_fetch.sv
// Scoreboard bench for the line fetch block: each fetch pushes its expected
// block result; a monitor pops and compares when done rises.
module tb_comperator_axi_ip_v1_0_line_fetch;

  localparam int BS = 8;
  localparam int DW = 24;
  localparam int CW = 4;
  localparam int BW = BS*DW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          go = 1'b0;
  logic          done, eol, sof, misalign;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic [BW-1:0] block_data;
  logic [CW-1:0] pix_count;

  comperator_axi_ip_v1_0_line_fetch #(.BLOCK_SIZE(BS), .DATA_WIDTH(DW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .go            (go),
    .done          (done),
    .eol           (eol),
    .sof           (sof),
    .misalign      (misalign),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .block_data    (block_data),
    .pix_count     (pix_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic          eol;
    logic          sof;
    logic          mis;
    int            pc;
    logic [BW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int cyc = 0;
  int last_beat_cyc = 0;
  int beat_cnt = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Cycle counter and accepted-beat bookkeeping seen from the bus side.
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (!aresetn) begin
      beat_cnt <= 0;
    end else if (go && !s_axis_tready) begin
      beat_cnt <= 0;
    end else if (s_axis_tvalid && s_axis_tready) begin
      beat_cnt      <= beat_cnt + 1;
      last_beat_cyc <= cyc;
    end
  end

  // Monitor: compare the block result when done rises.
  initial begin
    exp_t e;
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(negedge aclk);
      if (aresetn && done && !done_q) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_done: got done=1 expected no fetch pending");
        end else begin
          e = exp_q.pop_front();
          chk("done_latency", BW'(cyc - last_beat_cyc), BW'(1));
          chk("tready_at_done", BW'(s_axis_tready), BW'(0));
          chk("eol", BW'(eol), BW'(e.eol));
          chk("sof", BW'(sof), BW'(e.sof));
          chk("misalign", BW'(misalign), BW'(e.mis));
          chk("pix_count", BW'(pix_count), BW'(e.pc));
          chk("beats_accepted", BW'(beat_cnt), BW'(e.pc));
          chk("block_data", block_data, e.data);
        end
      end
      done_q = done;
    end
  end

  task automatic pulse_go();
    @(negedge aclk);
    go = 1'b1;
    @(negedge aclk);
    go = 1'b0;
  endtask

  // One fetch: pixels base+1..base+n, optional tlast/tuser beat (1-based,
  // 0 = none), tvalid gaps, go re-pulse on a beat, and extra refused beats.
  task automatic run_fetch(input logic [DW-1:0] base, input int n, input int last_at,
                           input int user_at, input bit toggle, input int go_at,
                           input int extra);
    exp_t e;
    int   w;
    e.eol  = (last_at == n);
    e.sof  = (user_at == 1);
    e.mis  = (user_at > 1) && (user_at <= n);
    e.pc   = n;
    e.data = '0;
    for (int i = 1; i <= n; i++) e.data[(i-1)*DW +: DW] = base + DW'(i);
    exp_q.push_back(e);
    pulse_go();
    for (int i = 1; i <= n; i++) begin
      w = 0;
      while (!s_axis_tready && w < 20) begin
        @(negedge aclk);
        w++;
      end
      if (w >= 20) chk("tready_wait", BW'(s_axis_tready), BW'(1));
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + DW'(i);
      s_axis_tlast  = (i == last_at);
      s_axis_tuser  = (i == user_at);
      go            = (i == go_at);
      @(negedge aclk);
      go            = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      if (toggle) @(negedge aclk);
    end
    if (extra > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 24'h999999;
      repeat (extra) @(negedge aclk);
      s_axis_tvalid = 1'b0;
    end
    w = 0;
    while (!done && w < 50) begin
      @(negedge aclk);
      w++;
    end
    if (w >= 50) chk("done_timeout", BW'(done), BW'(1));
    repeat (2) @(negedge aclk);
    chk("hold_done", BW'(done), BW'(1));
    chk("hold_pix_count", BW'(pix_count), BW'(n));
    chk("hold_block", block_data, e.data);
    chk("hold_beats", BW'(beat_cnt), BW'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $finish;
  end

  initial begin
    repeat (2) @(negedge aclk);
    chk("rst_done", BW'(done), BW'(0));
    chk("rst_tready", BW'(s_axis_tready), BW'(0));
    chk("rst_flags", BW'({eol, sof, misalign}), BW'(0));
    chk("rst_pix_count", BW'(pix_count), BW'(0));
    chk("rst_block", block_data, BW'(0));
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("idle_tready", BW'(s_axis_tready), BW'(0));

    // Full block, tuser on first beat, continuous valid.
    run_fetch(24'h000000, 8, 0, 1, 1'b0, 0, 0);
    // Early tlast on beat 5 with a 6th valid beat offered.
    run_fetch(24'h100000, 5, 5, 0, 1'b0, 0, 3);
    // tvalid toggling every cycle.
    run_fetch(24'h200000, 8, 0, 0, 1'b1, 0, 0);
    // tuser on beat 3 flags misalign, sof stays clear.
    run_fetch(24'h400000, 8, 0, 3, 1'b0, 0, 0);
    // Next go clears the status flags.
    pulse_go();
    chk("clr_misalign", BW'(misalign), BW'(0));
    chk("clr_sof", BW'(sof), BW'(0));
    chk("clr_done", BW'(done), BW'(0));
    chk("clr_pix_count", BW'(pix_count), BW'(0));
    chk("clr_block", block_data, BW'(0));
    exp_q.push_back('{eol: 1'b0, sof: 1'b1, mis: 1'b0, pc: 8,
                      data: {24'h500008, 24'h500007, 24'h500006, 24'h500005,
                             24'h500004, 24'h500003, 24'h500002, 24'h500001}});
    for (int i = 1; i <= 8; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 24'h500000 + DW'(i);
      s_axis_tuser  = (i == 1);
      @(negedge aclk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (3) @(negedge aclk);
    chk("b5_done", BW'(done), BW'(1));

    // Reset after three beats abandons the partial block.
    pulse_go();
    for (int i = 1; i <= 3; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 24'h600000 + DW'(i);
      @(negedge aclk);
    end
    chk("partial_pix_count", BW'(pix_count), BW'(3));
    #2 aresetn = 1'b0;
    #1;
    chk("arst_tready", BW'(s_axis_tready), BW'(0));
    chk("arst_done", BW'(done), BW'(0));
    chk("arst_flags", BW'({eol, sof, misalign}), BW'(0));
    chk("arst_pix_count", BW'(pix_count), BW'(0));
    chk("arst_block", block_data, BW'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    s_axis_tvalid = 1'b0;
    chk("post_rst_tready", BW'(s_axis_tready), BW'(0));
    chk("post_rst_pix_count", BW'(pix_count), BW'(0));
    chk("post_rst_block", block_data, BW'(0));
    run_fetch(24'h300000, 8, 0, 0, 1'b0, 0, 0);

    // go re-pulsed mid-fetch is ignored.
    run_fetch(24'h700000, 8, 0, 1, 1'b0, 4, 0);

    repeat (3) @(negedge aclk);
    chk("scoreboard_empty", BW'(exp_q.size()), BW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
